// File: rtl/calc_accum_datapath.sv
// Calculator accumulate datapath: decodes control-FSM toggles into events, assembles decimal entries, adds into a running total.
// Latency: a toggle change sampled at edge N is pending at N+2 and applied at N+3 at the earliest; digit strobes apply on the sampling edge.
// Backpressure: none; events are queued as pending bits (one per toggle, repeats merged) and serviced one per cycle by priority.
// Optional build macro SATURATE_EN: total saturates at all-ones on carry-out instead of wrapping.
module calc_accum_datapath #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             update_tgl,
    input  logic             show_tgl,
    input  logic             store_tgl,
    input  logic             clear_tgl,
    input  logic             digit_valid,
    input  logic [3:0]       digit,
    output logic [WIDTH-1:0] entry,
    output logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] total,
    output logic [WIDTH-1:0] display,
    output logic             show_total,
    output logic             overflow,
    output logic             entry_full,
    output logic             busy
);

    localparam int CW = $clog2(MAX_DIGITS + 1);

    // Bit positions inside the event vectors, highest index = highest priority.
    localparam int EV_SHOW   = 0;
    localparam int EV_UPDATE = 1;
    localparam int EV_STORE  = 2;
    localparam int EV_CLEAR  = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        SERVICE = 1'b1
    } state_t;

    state_t          state;
    logic [3:0]      tgl_in;
    logic [3:0]      sync1;
    logic [3:0]      sync2;
    logic [3:0]      last;
    logic [3:0]      edges;
    logic [3:0]      pend;
    logic [3:0]      pend_n;
    logic [3:0]      svc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_n;
    logic [WIDTH-1:0] entry_n;
    logic [WIDTH-1:0] entry_x10;
    logic [WIDTH:0]   sum;
    logic             digit_legal;
    logic             digit_ok;

    assign tgl_in = {clear_tgl, store_tgl, update_tgl, show_tgl};
    assign edges  = sync2 ^ last;

    // Two-flop synchronizer followed by the last-value register used for change detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            last  <= '0;
        end else begin
            sync1 <= tgl_in;
            sync2 <= sync1;
            last  <= sync2;
        end
    end

    // Pick the single highest-priority pending event and compute the next pending set.
    always_comb begin
        svc    = '0;
        pend_n = '0;
        if (pend[EV_CLEAR])       svc[EV_CLEAR]  = 1'b1;
        else if (pend[EV_STORE])  svc[EV_STORE]  = 1'b1;
        else if (pend[EV_UPDATE]) svc[EV_UPDATE] = 1'b1;
        else if (pend[EV_SHOW])   svc[EV_SHOW]   = 1'b1;
        // A clear also discards any change detected in the same cycle.
        if (svc[EV_CLEAR]) pend_n = '0;
        else               pend_n = (pend & ~svc) | edges;
    end

    // Service FSM: holds pending bits, tracks IDLE/SERVICE and registers busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pend  <= '0;
            busy  <= 1'b0;
        end else begin
            pend <= pend_n;
            busy <= |pend_n;
            case (state)
                IDLE:    if (|pend_n)  state <= SERVICE;
                SERVICE: if (!(|pend_n)) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign digit_legal = digit_valid && (digit <= 4'd9);
    assign digit_ok    = digit_legal && (count < CW'(MAX_DIGITS));
    assign entry_x10   = (entry << 3) + (entry << 1);
    assign sum         = {1'b0, total} + {1'b0, operand};

    // Next entry/count: a store empties the entry first, so a coincident digit starts a fresh entry.
    always_comb begin
        entry_n = entry;
        count_n = count;
        if (svc[EV_CLEAR]) begin
            entry_n = '0;
            count_n = '0;
        end else if (svc[EV_STORE]) begin
            if (digit_legal) begin
                entry_n = WIDTH'(digit);
                count_n = CW'(1);
            end else begin
                entry_n = '0;
                count_n = '0;
            end
        end else if (digit_ok) begin
            entry_n = entry_x10 + WIDTH'(digit);
            count_n = count + CW'(1);
        end
    end

    // Architectural registers: entry/count, operand, total, overflow and display select.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry      <= '0;
            count      <= '0;
            entry_full <= 1'b0;
            operand    <= '0;
            total      <= '0;
            overflow   <= 1'b0;
            show_total <= 1'b0;
        end else begin
            entry      <= entry_n;
            count      <= count_n;
            entry_full <= (count_n == CW'(MAX_DIGITS));
            if (svc[EV_CLEAR]) begin
                operand    <= '0;
                total      <= '0;
                overflow   <= 1'b0;
                show_total <= 1'b0;
            end else begin
                if (svc[EV_STORE]) operand <= entry;
                if (svc[EV_UPDATE]) begin
`ifdef SATURATE_EN
                    total <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
                    total <= sum[WIDTH-1:0];
`endif
                    overflow <= overflow | sum[WIDTH];
                end
                if (svc[EV_SHOW]) show_total <= ~show_total;
            end
        end
    end

    assign display = show_total ? total : entry;

endmodule

// File: tb/tb_calc_accum_datapath.sv
// Directed bench for calc_accum_datapath: reset, digit entry, store/update/show, priorities, overflow, clear and reset mid-service.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// All expectations are hand-computed constants.
module tb_calc_accum_datapath;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             update_tgl = 1'b0;
    logic             show_tgl = 1'b0;
    logic             store_tgl = 1'b0;
    logic             clear_tgl = 1'b0;
    logic             digit_valid = 1'b0;
    logic [3:0]       digit = 4'd0;
    logic [WIDTH-1:0] entry;
    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] total;
    logic [WIDTH-1:0] display;
    logic             show_total;
    logic             overflow;
    logic             entry_full;
    logic             busy;

    int tests = 0;
    int fails = 0;

    calc_accum_datapath #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
        .clk(clk), .reset(reset),
        .update_tgl(update_tgl), .show_tgl(show_tgl), .store_tgl(store_tgl), .clear_tgl(clear_tgl),
        .digit_valid(digit_valid), .digit(digit),
        .entry(entry), .operand(operand), .total(total), .display(display),
        .show_total(show_total), .overflow(overflow), .entry_full(entry_full), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        tick();
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic do_clear();
        clear_tgl = ~clear_tgl;
        wait_cyc(6);
    endtask

    task automatic do_store();
        store_tgl = ~store_tgl;
        wait_cyc(6);
    endtask

    task automatic do_update();
        update_tgl = ~update_tgl;
        wait_cyc(6);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cyc(2);
        tests++;
        if ({entry, operand, total, display} !== '0 || {show_total, overflow, entry_full, busy} !== 4'b0) begin
            fails++;
            $display("FAIL reset_state: entry=%0d operand=%0d total=%0d display=%0d flags=%b, expected all 0",
                     entry, operand, total, display, {show_total, overflow, entry_full, busy});
        end
        reset = 1'b0;
        wait_cyc(3);
        key(4'd1); key(4'd2); key(4'd3);
        tests++;
        if (entry !== 16'd123 || entry_full !== 1'b0 || display !== 16'd123 || busy !== 1'b0) begin
            fails++;
            $display("FAIL digits_123: entry=%0d full=%b display=%0d busy=%b, expected 123 0 123 0",
                     entry, entry_full, display, busy);
        end
    endtask

    task automatic test_digit_limits();
        do_clear();
        key(4'd4); key(4'd5); key(4'd6); key(4'd7);
        tests++;
        if (entry !== 16'd4567 || entry_full !== 1'b1) begin
            fails++;
            $display("FAIL four_digits: entry=%0d full=%b, expected 4567 1", entry, entry_full);
        end
        key(4'd8);
        tests++;
        if (entry !== 16'd4567 || entry_full !== 1'b1) begin
            fails++;
            $display("FAIL fifth_digit: entry=%0d full=%b, expected 4567 1", entry, entry_full);
        end
        do_clear();
        key(4'd11);
        tests++;
        if (entry !== 16'd0 || entry_full !== 1'b0) begin
            fails++;
            $display("FAIL illegal_digit: entry=%0d full=%b, expected 0 0", entry, entry_full);
        end
        key(4'd9);
        tests++;
        if (entry !== 16'd9) begin
            fails++;
            $display("FAIL digit_after_illegal: entry=%0d, expected 9", entry);
        end
    endtask

    task automatic test_store_update_show();
        do_clear();
        key(4'd2); key(4'd5); key(4'd0);
        store_tgl = ~store_tgl;
        wait_cyc(3);
        tests++;
        if (busy !== 1'b1 || operand !== 16'd0 || entry !== 16'd250) begin
            fails++;
            $display("FAIL store_pending: busy=%b operand=%0d entry=%0d, expected 1 0 250", busy, operand, entry);
        end
        tick();
        tests++;
        if (operand !== 16'd250 || entry !== 16'd0) begin
            fails++;
            $display("FAIL store_n3: operand=%0d entry=%0d, expected 250 0", operand, entry);
        end
        do_update();
        do_update();
        tests++;
        if (total !== 16'd500 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL update_twice: total=%0d ovf=%b, expected 500 0", total, overflow);
        end
        show_tgl = ~show_tgl;
        wait_cyc(6);
        tests++;
        if (show_total !== 1'b1 || display !== 16'd500) begin
            fails++;
            $display("FAIL show: show_total=%b display=%0d, expected 1 500", show_total, display);
        end
    endtask

    task automatic test_back_to_back();
        int bcnt;
        do_clear();
        key(4'd3);
        do_store();
        key(4'd7);
        store_tgl  = ~store_tgl;
        update_tgl = ~update_tgl;
        bcnt = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (busy === 1'b1) bcnt++;
            if (i == 4) begin
                tests++;
                if (operand !== 16'd7 || total !== 16'd0) begin
                    fails++;
                    $display("FAIL b2b_store_first: operand=%0d total=%0d, expected 7 0", operand, total);
                end
            end
            if (i == 5) begin
                tests++;
                if (total !== 16'd7) begin
                    fails++;
                    $display("FAIL b2b_update_next: total=%0d, expected 7", total);
                end
            end
        end
        tests++;
        if (bcnt != 2) begin
            fails++;
            $display("FAIL b2b_busy_cycles: busy high %0d cycles, expected 2", bcnt);
        end
    endtask

    task automatic test_digit_with_store();
        do_clear();
        key(4'd1); key(4'd2);
        store_tgl = ~store_tgl;
        wait_cyc(3);
        key(4'd5);
        tests++;
        if (operand !== 16'd12 || entry !== 16'd5 || entry_full !== 1'b0) begin
            fails++;
            $display("FAIL digit_with_store: operand=%0d entry=%0d full=%b, expected 12 5 0",
                     operand, entry, entry_full);
        end
        key(4'd6);
        tests++;
        if (entry !== 16'd56) begin
            fails++;
            $display("FAIL digit_after_store: entry=%0d, expected 56", entry);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        do_store();
        repeat (6) do_update();
        key(4'd5); key(4'd5); key(4'd2); key(4'd6);
        do_store();
        do_update();
        tests++;
        if (total !== 16'hFFF0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL pre_overflow: total=%h ovf=%b, expected fff0 0", total, overflow);
        end
        key(4'd3); key(4'd2);
        do_store();
        do_update();
        tests++;
`ifdef SATURATE_EN
        if (total !== 16'hFFFF || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_sat: total=%h ovf=%b, expected ffff 1", total, overflow);
        end
`else
        if (total !== 16'h0010 || overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_wrap: total=%h ovf=%b, expected 0010 1", total, overflow);
        end
`endif
    endtask

    task automatic test_clear_show();
        do_clear();
        tests++;
        if (overflow !== 1'b0 || total !== 16'd0) begin
            fails++;
            $display("FAIL clear_overflow: total=%h ovf=%b, expected 0 0", total, overflow);
        end
        key(4'd2); key(4'd5); key(4'd0);
        do_store();
        do_update();
        do_update();
        key(4'd8);
        clear_tgl = ~clear_tgl;
        show_tgl  = ~show_tgl;
        wait_cyc(8);
        tests++;
        if ({entry, operand, total, display} !== '0 || {show_total, overflow, entry_full, busy} !== 4'b0) begin
            fails++;
            $display("FAIL clear_with_show: entry=%0d operand=%0d total=%0d display=%0d flags=%b, expected all 0",
                     entry, operand, total, display, {show_total, overflow, entry_full, busy});
        end
    endtask

    task automatic test_reset_mid_service();
        key(4'd4);
        store_tgl  = ~store_tgl;
        update_tgl = ~update_tgl;
        show_tgl   = ~show_tgl;
        wait_cyc(3);
        tests++;
        if (busy !== 1'b1 || entry !== 16'd4) begin
            fails++;
            $display("FAIL mid_pending: busy=%b entry=%0d, expected 1 4", busy, entry);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || entry !== 16'd0 || display !== 16'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%b entry=%0d display=%0d, expected 0 0 0", busy, entry, display);
        end
        tick();
        reset = 1'b0;
        // Toggles held at 1 through reset release each produce one event.
        wait_cyc(10);
        tests++;
        if (show_total !== 1'b1 || busy !== 1'b0 || total !== 16'd0 || operand !== 16'd0) begin
            fails++;
            $display("FAIL post_reset_events: show_total=%b busy=%b total=%0d operand=%0d, expected 1 0 0 0",
                     show_total, busy, total, operand);
        end
    endtask

    initial begin
        test_reset();
        test_digit_limits();
        test_store_update_show();
        test_back_to_back();
        test_digit_with_store();
        test_overflow();
        test_clear_show();
        test_reset_mid_service();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
